// File: rtl/bar_viz_pkg.sv
// bar_viz_pkg: types and constants shared by the bar-graph video path.
//   NUM_BANDS / BAND_W : number of bands and the band index width
//   HEIGHT_W / MAX_HEIGHT : bar height width and saturation ceiling
//   HOLD_FRAMES : peak-marker hold time (used only with PEAK_MARKER_EN)
//   band_t, height_t, tracker_state_t : shared typedefs
//   decay_sat() : subtract with a floor at zero
package bar_viz_pkg;

    localparam int NUM_BANDS   = 16;
    localparam int BAND_W      = $clog2(NUM_BANDS);
    localparam int HEIGHT_W    = 9;
    localparam int MAX_HEIGHT  = 400;
    localparam int HOLD_FRAMES = 30;

    typedef logic [BAND_W-1:0]   band_t;
    typedef logic [HEIGHT_W-1:0] height_t;

    typedef enum logic {
        IDLE,
        DECAY
    } tracker_state_t;

    function automatic height_t decay_sat(input height_t h, input height_t step);
        return (h > step) ? height_t'(h - step) : '0;
    endfunction

endpackage

// File: rtl/magnitude_scaler.sv
// magnitude_scaler: combinational conversion of a signed sample to a bar height.
//   sample : signed two's-complement input sample
//   shift  : right shift applied to the magnitude
//   height : |sample| >> shift, clamped to MAX_HEIGHT
module magnitude_scaler
    import bar_viz_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [3:0]          shift,
    output height_t                    height
);

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] shifted;

    always_comb begin
        mag = sample;
        // The most negative value has no positive twin; saturate it.
        if (sample == MOST_NEG) begin
            mag = MOST_POS;
        end else if (sample[SAMPLE_W-1]) begin
            mag = -sample;
        end
    end

    assign shifted = mag >> shift;

    always_comb begin
        height = shifted[HEIGHT_W-1:0];
        if (shifted > SAMPLE_W'(MAX_HEIGHT)) begin
            height = height_t'(MAX_HEIGHT);
        end
    end

endmodule

// File: rtl/band_level_tracker.sv
// band_level_tracker: per-band bar heights with instant attack and a linear
// per-frame decay sweep, read by bar_graph through a synchronous read port.
//   MAX10_CLK1_50 : system clock          Reset    : async reset, active-low
//   in_valid/in_ready/in_band/in_sample   : sample handshake
//   gain_shift    : magnitude right shift frame_tick : start-of-blanking pulse
//   busy          : decay sweep running
//   rd_band -> rd_height / rd_peak        : 1-cycle-latency read port
// Build option: define PEAK_MARKER_EN for per-band peak-hold markers;
// otherwise rd_peak mirrors rd_height.
module band_level_tracker
    import bar_viz_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int DECAY_STEP = 4
) (
    input  logic                       MAX10_CLK1_50,
    input  logic                       Reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  band_t                      in_band,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic        [3:0]          gain_shift,
    input  logic                       frame_tick,
    output logic                       busy,
    input  band_t                      rd_band,
    output height_t                    rd_height,
    output height_t                    rd_peak
);

    localparam height_t DSTEP     = height_t'(DECAY_STEP);
    localparam band_t   LAST_BAND = band_t'(NUM_BANDS - 1);

    tracker_state_t state;
    logic           pending;
    band_t          sweep_idx;
    height_t        level [NUM_BANDS];
    height_t        scaled;
    height_t        lvl_dec;
    logic           in_ok;
    logic           rd_ok;

    magnitude_scaler #(.SAMPLE_W(SAMPLE_W)) u_scaler (
        .sample (in_sample),
        .shift  (gain_shift),
        .height (scaled)
    );

    // Range checks only exist when the index width can exceed the band count.
    if (NUM_BANDS < (1 << BAND_W)) begin : g_partial
        assign in_ok = (int'(in_band) < NUM_BANDS);
        assign rd_ok = (int'(rd_band) < NUM_BANDS);
    end else begin : g_full
        assign in_ok = 1'b1;
        assign rd_ok = 1'b1;
    end

    assign lvl_dec = decay_sat(level[sweep_idx], DSTEP);

`ifdef PEAK_MARKER_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    height_t           peak [NUM_BANDS];
    logic [HOLD_W-1:0] hold [NUM_BANDS];
    height_t           pk_dec;
    height_t           pk_next;

    assign pk_dec  = decay_sat(peak[sweep_idx], DSTEP);
    // The marker never falls below the bar it sits on.
    assign pk_next = (pk_dec > lvl_dec) ? pk_dec : lvl_dec;
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            sweep_idx <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                level[i] <= '0;
`ifdef PEAK_MARKER_EN
                peak[i]  <= '0;
                hold[i]  <= '0;
`endif
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready && in_ok) begin
                        if (scaled > level[in_band]) begin
                            level[in_band] <= scaled;
                        end
`ifdef PEAK_MARKER_EN
                        if (scaled >= peak[in_band]) begin
                            peak[in_band] <= scaled;
                            hold[in_band] <= HOLD_W'(HOLD_FRAMES);
                        end
`endif
                    end
                    // A sample accepted on this edge is written before the sweep.
                    if (frame_tick || pending) begin
                        state     <= DECAY;
                        pending   <= 1'b0;
                        sweep_idx <= '0;
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                DECAY: begin
                    level[sweep_idx] <= lvl_dec;
`ifdef PEAK_MARKER_EN
                    if (hold[sweep_idx] != '0) begin
                        hold[sweep_idx] <= hold[sweep_idx] - 1'b1;
                    end else begin
                        peak[sweep_idx] <= pk_next;
                    end
`endif
                    if (sweep_idx == LAST_BAND) begin
                        // A tick seen during the sweep restarts it back-to-back.
                        if (pending || frame_tick) begin
                            pending   <= 1'b0;
                            sweep_idx <= '0;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        sweep_idx <= sweep_idx + band_t'(1);
                        if (frame_tick) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset) begin
        if (!Reset) begin
            rd_height <= '0;
`ifdef PEAK_MARKER_EN
            rd_peak   <= '0;
`endif
        end else begin
            rd_height <= rd_ok ? level[rd_band] : '0;
`ifdef PEAK_MARKER_EN
            rd_peak   <= rd_ok ? peak[rd_band] : '0;
`endif
        end
    end

`ifndef PEAK_MARKER_EN
    assign rd_peak = rd_height;
`endif

endmodule

// File: tb/tb_band_level_tracker.sv
// tb_band_level_tracker: directed plus randomized checks of band_level_tracker
// against a frame-level reference model of levels, peaks and sweep timing.
module tb_band_level_tracker;
    import bar_viz_pkg::*;

    localparam int DSTEP = 4;
    localparam int HOLD  = HOLD_FRAMES;

    logic               clk = 1'b0;
    logic               Reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    band_t              in_band = '0;
    logic signed [15:0] in_sample = '0;
    logic        [3:0]  gain_shift = 4'd6;
    logic               frame_tick = 1'b0;
    logic               busy;
    band_t              rd_band = '0;
    height_t            rd_height;
    height_t            rd_peak;

    band_level_tracker #(.SAMPLE_W(16), .DECAY_STEP(DSTEP)) dut (
        .MAX10_CLK1_50 (clk),
        .Reset         (Reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_band       (in_band),
        .in_sample     (in_sample),
        .gain_shift    (gain_shift),
        .frame_tick    (frame_tick),
        .busy          (busy),
        .rd_band       (rd_band),
        .rd_height     (rd_height),
        .rd_peak       (rd_peak)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    int lvl [NUM_BANDS];
    int pk  [NUM_BANDS];
    int hld [NUM_BANDS];
    int m_pos;      // next band to decay, -1 when no sweep is running
    bit m_pend;
    bit m_ready;
    bit last_accept;
    int e_h, e_p;
    bit e_ready, e_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scale(input logic signed [15:0] s, input int g);
        int m;
        m = int'(s);
        if (m < 0) m = -m;
        if (m > 32767) m = 32767;
        m = m >> g;
        return (m > MAX_HEIGHT) ? MAX_HEIGHT : m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_BANDS; i++) begin
            lvl[i] = 0; pk[i] = 0; hld[i] = 0;
        end
        m_pos = -1; m_pend = 0; m_ready = 0; last_accept = 0;
        e_h = 0; e_p = 0; e_ready = 0; e_busy = 0;
    endtask

    task automatic model_edge();
        int b, sc, nl, np;
        e_h = (int'(rd_band) < NUM_BANDS) ? lvl[rd_band] : 0;
`ifdef PEAK_MARKER_EN
        e_p = (int'(rd_band) < NUM_BANDS) ? pk[rd_band] : 0;
`else
        e_p = e_h;
`endif
        last_accept = in_valid && m_ready;
        b = int'(in_band);
        if (last_accept && b < NUM_BANDS) begin
            sc = scale(in_sample, int'(gain_shift));
            if (sc > lvl[b]) lvl[b] = sc;
`ifdef PEAK_MARKER_EN
            if (sc >= pk[b]) begin pk[b] = sc; hld[b] = HOLD; end
`endif
        end
        if (m_pos < 0) begin
            if (frame_tick || m_pend) begin
                m_pos = 0; m_pend = 0; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end else begin
            nl = lvl[m_pos] - DSTEP;
            if (nl < 0) nl = 0;
            lvl[m_pos] = nl;
`ifdef PEAK_MARKER_EN
            if (hld[m_pos] > 0) begin
                hld[m_pos]--;
            end else begin
                np = pk[m_pos] - DSTEP;
                if (np < nl) np = nl;
                pk[m_pos] = np;
            end
`else
            np = 0;
`endif
            if (m_pos == NUM_BANDS - 1) begin
                if (m_pend || frame_tick) begin
                    m_pos = 0; m_pend = 0;
                end else begin
                    m_pos = -1; m_ready = 1;
                end
            end else begin
                m_pos++;
                if (frame_tick) m_pend = 1;
            end
        end
        e_ready = m_ready;
        e_busy  = (m_pos >= 0);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("in_ready", in_ready, e_ready);
        check_eq("busy", busy, e_busy);
        check_eq("rd_height", rd_height, e_h);
        check_eq("rd_peak", rd_peak, e_p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_rd_height", rd_height, 0);
        check_eq("rst_rd_peak", rd_peak, 0);
        model_reset();
        in_valid = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        step();
    endtask

    task automatic send(input int band, input int sample, input int gain);
        in_band = band_t'(band);
        in_sample = 16'(sample);
        gain_shift = 4'(gain);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (last_accept) break;
        end
        check_eq("send_accept", last_accept, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_idle();
        for (int k = 0; k < 100; k++) begin
            if (m_pos < 0 && !m_pend) break;
            step();
        end
        check_eq("sweep_done", busy, 0);
    endtask

    task automatic read_chk(input string tag, input int band, input int exp);
        rd_band = band_t'(band);
        step();
        check_eq(tag, rd_height, exp);
    endtask

    task automatic tick_sweep();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        run_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        model_reset();
        #3 Reset = 1'b0;
        do_reset();

        // attack and hold-higher behaviour
        send(3, 6400, 6);
        send(5, -12800, 6);
        send(3, 50, 6);
        send(9, 128, 6);
        read_chk("b3_attack", 3, 100);
        read_chk("b5_attack", 5, 200);

        // one sweep: length and band 3 update timing
        frame_tick = 1'b1;
        rd_band = 3;
        step();
        frame_tick = 1'b0;
        cnt = busy;
        for (int k = 1; k <= 20; k++) begin
            step();
            cnt += busy;
            if (k == 4) check_eq("b3_before_update", rd_height, 100);
            if (k == 5) check_eq("b3_after_update", rd_height, 96);
        end
        check_eq("busy_len", cnt, 16);
        read_chk("b5_decay", 5, 196);
        read_chk("b9_floor", 9, 0);

        // magnitude saturation and clamp
        send(0, 32767, 0);
        read_chk("b0_clamp", 0, 400);
        send(1, -32768, 6);
        read_chk("b1_most_neg", 1, 400);

        // valid held across a sweep
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        cnt = in_ready ? 0 : 1;
        in_band = 2; in_sample = 640; gain_shift = 6; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!in_ready) cnt++;
            if (last_accept) break;
        end
        in_valid = 1'b0;
        check_eq("ready_low_len", cnt, 16);
        read_chk("b2_held", 2, 10);

        // same-edge sample and tick, then a second tick mid-sweep
        in_band = 7; in_sample = 16'(300 * 64); gain_shift = 6;
        in_valid = 1'b1; frame_tick = 1'b1;
        step();
        check_eq("same_edge_accept", last_accept, 1);
        in_valid = 1'b0; frame_tick = 1'b0;
        cnt = busy;
        for (int k = 0; k < 40; k++) begin
            frame_tick = (k == 5);
            if (k == 17) begin
                rd_band = 7;
            end
            step();
            cnt += busy;
            if (k == 18) check_eq("b7_first_sweep", rd_height, 296);
        end
        frame_tick = 1'b0;
        check_eq("double_sweep_len", cnt, 32);
        read_chk("b7_second_sweep", 7, 292);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_accept) begin
                in_valid = 1'($urandom_range(0, 1));
                in_band = band_t'($urandom);
                in_sample = 16'($urandom);
                gain_shift = 4'($urandom_range(0, 9));
            end
            frame_tick = ($urandom_range(0, 29) == 0);
            rd_band = band_t'($urandom);
            step();
        end
        in_valid = 1'b0;
        frame_tick = 1'b0;
        run_idle();

`ifdef PEAK_MARKER_EN
        do_reset();
        send(4, 200 * 64, 6);
        for (int f = 0; f < 30; f++) tick_sweep();
        rd_band = 4;
        step();
        check_eq("peak_held", rd_peak, 200);
        check_eq("level_under_peak", rd_height, 80);
        tick_sweep();
        step();
        check_eq("peak_released", rd_peak, 196);
        check_eq("level_after_release", rd_height, 76);
`endif

        // reset in the middle of a sweep
        send(6, 64 * 123, 6);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (5) step();
        do_reset();
        for (int i = 0; i < NUM_BANDS; i++) begin
            read_chk("post_reset_zero", i, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
